// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the packet-atomic round-robin FIFO write arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Smallest number of bits able to index value distinct items.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      result = ((32'sd1 <<< i) < value) ? (i + 1) : result;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, with ptr itself checked last.
module rr_picker #(
  parameter int NumPorts    = 4,
  parameter int PortIdWidth = 2
) (
  input  logic [NumPorts-1:0]    req,
  input  logic [PortIdWidth-1:0] ptr,
  output logic                   found,
  output logic [PortIdWidth-1:0] idx
);

  // Scan from ptr+1 upward; the first hit wins and later hits are ignored.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      j     = (int'(ptr) + k) % NumPorts;
      idx   = (!found && req[j]) ? PortIdWidth'(j) : idx;
      found = found | req[j];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port among
// NumPorts requesters; a grant lasts until the owner's last flit is written.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NumPorts    = 4,
  parameter int DataWidth   = 64,
  parameter int PortIdWidth = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumPorts-1:0]           req_valid,
  input  logic [NumPorts-1:0]           req_last,
  input  logic [NumPorts*DataWidth-1:0] req_data,
  output logic [NumPorts-1:0]           req_ready,
  output logic                          fifo_wr_req,
  output logic [DataWidth-1:0]          fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic                          grant_valid,
  output logic [PortIdWidth-1:0]        grant_id
);

  arb_state_e                state_q, state_d;
  logic [PortIdWidth-1:0]    grant_q, grant_d;
  logic [PortIdWidth-1:0]    rr_q, rr_d;

  logic [NumPorts-1:0]       grant_onehot_s;
  logic [DataWidth-1:0]      mux_data_s;
  logic [NumPorts-1:0]       pick_req_s;
  logic [PortIdWidth-1:0]    pick_ptr_s;
  logic                      pick_found_s;
  logic [PortIdWidth-1:0]    pick_idx_s;
  logic                      busy_s;
  logic                      xfer_s;
  logic                      last_s;

  // Decode the owner into a one-hot mask and select its flit data.
  always_comb begin
    grant_onehot_s = '0;
    mux_data_s     = '0;
    for (int i = 0; i < NumPorts; i++) begin
      grant_onehot_s[i] = (grant_q == PortIdWidth'(i));
      mux_data_s        = grant_onehot_s[i] ? req_data[i*DataWidth +: DataWidth] : mux_data_s;
    end
  end

  assign busy_s = (state_q == ST_BUSY);
  assign xfer_s = busy_s && (|(req_valid & grant_onehot_s)) && !fifo_wr_full;
  assign last_s = |(req_last & grant_onehot_s);

  // While busy, the owner's consumed flit is masked so a different port takes over.
  assign pick_req_s = busy_s ? (req_valid & ~grant_onehot_s) : req_valid;
  assign pick_ptr_s = busy_s ? grant_q : rr_q;

  rr_picker #(
    .NumPorts    (NumPorts),
    .PortIdWidth (PortIdWidth)
  ) u_rr_picker (
    .req   (pick_req_s),
    .ptr   (pick_ptr_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state logic: arbitrate from idle, or hand over at the end of a packet.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_BUSY;
          grant_d = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (xfer_s && last_s) begin
          rr_d = grant_q;
          if (pick_found_s) begin
            grant_d = pick_idx_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer; the pointer starts at the top port so port 0 goes first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= PortIdWidth'(NumPorts - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign req_ready    = (busy_s && !fifo_wr_full) ? grant_onehot_s : '0;
  assign fifo_wr_req  = xfer_s;
  assign fifo_wr_data = mux_data_s;
  assign grant_valid  = busy_s;
  assign grant_id     = grant_q;

endmodule
